// File: rtl/dcsk_pkg.sv
// rtl/dcsk_pkg.sv - shared FSM state, spreading-factor helper and default generator constants for the DCSK transmitter
package dcsk_pkg;

  // Phase of the chip currently driven on the output
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REF  = 2'd1,
    ST_DATA = 2'd2
  } tx_state_e;

  localparam logic [7:0] POLY_DEF         = 8'hB8;
  localparam logic [7:0] SEED_RST_DEF     = 8'h01;
  localparam int         SF_MIN_LOG2_DEF  = 2;

  // Chips per half-symbol for spreading-factor ID `id`
  function automatic int unsigned sf_chips(input int unsigned id, input int unsigned min_log2);
    return 32'd1 << (min_log2 + id);
  endfunction

endpackage

// File: rtl/dcsk_chaos_gen.sv
// rtl/dcsk_chaos_gen.sv - Galois chaos-chip generator with seed load, advance and zero-seed substitution
module dcsk_chaos_gen #(
  parameter int                SEED_W   = 8,
  parameter logic [SEED_W-1:0] POLY     = 8'hB8,
  parameter logic [SEED_W-1:0] SEED_RST = 8'h01
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic              i_load,
  input  logic [SEED_W-1:0] i_seed,
  input  logic              i_adv,
  output logic              o_chip
);

  logic [SEED_W-1:0] state_q;
  logic [SEED_W-1:0] state_d;
  logic [SEED_W-1:0] state_eff;

  // A load in the same cycle as a frame start must feed that frame, so the
  // chip and the next state are taken from the freshly loaded value
  always_comb begin
    state_eff = state_q;
    if (i_load) begin
      state_eff = (i_seed == '0) ? SEED_W'(1) : i_seed;
    end
    state_d = state_eff;
    if (i_adv) begin
      state_d = (state_eff >> 1) ^ (state_eff[0] ? POLY : '0);
    end
  end

  assign o_chip = state_eff[0];

  // Generator state register; persists across frames
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= SEED_RST;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/dcsk_tx_param.sv
// rtl/dcsk_tx_param.sv - DCSK chip-stream transmitter with one-entry pending frame (option: DCSK_TX_PARITY_EN)
module dcsk_tx_param
  import dcsk_pkg::*;
#(
  parameter int                MSG_W       = 32,
  parameter int                SEED_W      = 8,
  parameter logic [SEED_W-1:0] POLY        = POLY_DEF,
  parameter logic [SEED_W-1:0] SEED_RST    = SEED_RST_DEF,
  parameter int                SF_ID_W     = 2,
  parameter int                SF_MIN_LOG2 = SF_MIN_LOG2_DEF
) (
  input  logic               i_clk,
  input  logic               i_arst_n,
  input  logic [MSG_W-1:0]   i_msg,
  input  logic               i_send,
  output logic               o_ready,
  input  logic [SF_ID_W-1:0] i_sf,
  input  logic [SEED_W-1:0]  i_seed,
  input  logic               i_load_seed,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_done
);

`ifdef DCSK_TX_PARITY_EN
  localparam int NBITS = MSG_W + 1;
`else
  localparam int NBITS = MSG_W;
`endif
  localparam int SF_MAX_LOG2 = SF_MIN_LOG2 + (1 << SF_ID_W) - 1;
  localparam int SF_MAX      = 1 << SF_MAX_LOG2;
  localparam int CNT_W       = SF_MAX_LOG2 + 1;
  localparam int IDX_W       = SF_MAX_LOG2;
  localparam int BIT_W       = $clog2(NBITS + 1);

  // Symbols of a frame in transmit order, MSB first, parity last when enabled
  function automatic logic [NBITS-1:0] frame_bits(input logic [MSG_W-1:0] m);
`ifdef DCSK_TX_PARITY_EN
    return {m, ^m};
`else
    return m;
`endif
  endfunction

  tx_state_e          state_q;
  logic [NBITS-1:0]   bits_q;
  logic [SF_ID_W-1:0] sf_q;
  logic [CNT_W-1:0]   chip_q;
  logic [BIT_W-1:0]   bit_q;
  logic               pend_valid_q;
  logic [NBITS-1:0]   pend_bits_q;
  logic [SF_ID_W-1:0] pend_sf_q;
  logic               tx_q;
  logic               busy_q;
  logic               done_q;
  logic               cbuf_q [SF_MAX];

  logic               is_idle;
  logic               accept;
  logic [CNT_W-1:0]   sf_last;
  logic [CNT_W-1:0]   chip_inc;
  logic               last_chip;
  logic               last_bit;
  logic               frame_end;
  logic               gen_chip;
  logic               gen_adv;
  logic               gen_load;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic               data_chip;

  assign is_idle   = (state_q == ST_IDLE);
  assign accept    = i_send & ~pend_valid_q;
  assign sf_last   = CNT_W'(sf_chips(32'(sf_q), SF_MIN_LOG2) - 32'd1);
  assign chip_inc  = chip_q + CNT_W'(1);
  assign last_chip = (chip_q == sf_last);
  assign last_bit  = (bit_q == BIT_W'(NBITS - 1));
  assign frame_end = (state_q == ST_DATA) & last_chip & last_bit;

  // The generator steps whenever the next chip on the output is a reference chip
  assign gen_load = is_idle & i_load_seed;
  assign gen_adv  = (is_idle & accept)
                  | ((state_q == ST_REF) & ~last_chip)
                  | ((state_q == ST_DATA) & last_chip & (~last_bit | pend_valid_q | i_send));

  // Reference chip k is stored at k; the data half replays from index 0
  assign wr_idx    = (state_q == ST_REF) ? chip_inc[IDX_W-1:0] : '0;
  assign rd_idx    = (state_q == ST_REF) ? '0 : chip_inc[IDX_W-1:0];
  assign data_chip = ~(cbuf_q[rd_idx] ^ bits_q[NBITS-1]);

  dcsk_chaos_gen #(
    .SEED_W   (SEED_W),
    .POLY     (POLY),
    .SEED_RST (SEED_RST)
  ) u_gen (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_load   (gen_load),
    .i_seed   (i_seed),
    .i_adv    (gen_adv),
    .o_chip   (gen_chip)
  );

  // Reference-half chip buffer
  always_ff @(posedge i_clk) begin
    if (gen_adv) begin
      cbuf_q[wr_idx] <= gen_chip;
    end
  end

  // Frame sequencing, pending slot and registered outputs
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q      <= ST_IDLE;
      bits_q       <= '0;
      sf_q         <= '0;
      chip_q       <= '0;
      bit_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_bits_q  <= '0;
      pend_sf_q    <= '0;
      tx_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Mid-frame offers park in the pending slot; at frame end they start directly
      if (accept && !is_idle && !frame_end) begin
        pend_valid_q <= 1'b1;
        pend_bits_q  <= frame_bits(i_msg);
        pend_sf_q    <= i_sf;
      end
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b0;
          if (accept) begin
            state_q <= ST_REF;
            chip_q  <= '0;
            bit_q   <= '0;
            bits_q  <= frame_bits(i_msg);
            sf_q    <= i_sf;
            tx_q    <= gen_chip;
            busy_q  <= 1'b1;
          end
        end
        ST_REF: begin
          if (last_chip) begin
            state_q <= ST_DATA;
            chip_q  <= '0;
            tx_q    <= data_chip;
          end else begin
            chip_q <= chip_inc;
            tx_q   <= gen_chip;
          end
        end
        ST_DATA: begin
          if (!last_chip) begin
            chip_q <= chip_inc;
            tx_q   <= data_chip;
          end else if (!last_bit) begin
            state_q <= ST_REF;
            chip_q  <= '0;
            bit_q   <= bit_q + BIT_W'(1);
            bits_q  <= bits_q << 1;
            tx_q    <= gen_chip;
          end else begin
            done_q <= 1'b1;
            chip_q <= '0;
            bit_q  <= '0;
            if (pend_valid_q) begin
              state_q      <= ST_REF;
              bits_q       <= pend_bits_q;
              sf_q         <= pend_sf_q;
              pend_valid_q <= 1'b0;
              tx_q         <= gen_chip;
            end else if (i_send) begin
              state_q <= ST_REF;
              bits_q  <= frame_bits(i_msg);
              sf_q    <= i_sf;
              tx_q    <= gen_chip;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              tx_q    <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          tx_q    <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx    = tx_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_ready = ~pend_valid_q;

endmodule

// File: tb/tb_dcsk_tx_param.sv
// tb/tb_dcsk_tx_param.sv - directed self-checking bench for dcsk_tx_param (MSG_W=4)
module tb_dcsk_tx_param;

`ifdef DCSK_TX_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] i_msg;
  logic       i_send;
  logic       o_ready;
  logic [1:0] i_sf;
  logic [7:0] i_seed;
  logic       i_load_seed;
  logic       o_tx;
  logic       o_busy;
  logic       o_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mstate;
  logic [63:0] obs_sym [8];
  logic [7:0]  dir_tbl [4];

  always #5 clk = ~clk;

  dcsk_tx_param #(
    .MSG_W (4)
  ) dut (
    .i_clk       (clk),
    .i_arst_n    (rst_n),
    .i_msg       (i_msg),
    .i_send      (i_send),
    .o_ready     (o_ready),
    .i_sf        (i_sf),
    .i_seed      (i_seed),
    .i_load_seed (i_load_seed),
    .o_tx        (o_tx),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [NB-1:0] fbits(input logic [3:0] m);
`ifdef DCSK_TX_PARITY_EN
    return {m, ^m};
`else
    return m;
`endif
  endfunction

  // Offer a frame at a negedge; returns at the negedge showing its first chip
  task automatic start(input logic [3:0] msg, input logic [1:0] sf, input logic ld, input logic [7:0] seed);
    i_msg = msg; i_sf = sf; i_send = 1'b1; i_load_seed = ld; i_seed = seed;
    @(negedge clk);
    i_send = 1'b0; i_load_seed = 1'b0;
  endtask

  // Sample one frame from the current negedge on; compare each symbol against the model
  task automatic collect(input logic [3:0] msg, input logic [1:0] sf, input string tag);
    int          sfc;
    logic [NB-1:0] fb;
    logic [63:0] obs;
    logic [63:0] expv;
    logic        rbuf [32];
    sfc = 4 << sf;
    fb  = fbits(msg);
    for (int b = 0; b < NB; b++) begin
      obs  = '0;
      expv = '0;
      for (int k = 0; k < sfc; k++) begin
        rbuf[k] = mstate[0];
        expv    = {expv[62:0], mstate[0]};
        mstate  = (mstate >> 1) ^ (mstate[0] ? 8'hB8 : 8'h00);
      end
      for (int k = 0; k < sfc; k++) expv = {expv[62:0], ~(rbuf[k] ^ fb[NB-1-b])};
      for (int c = 0; c < 2 * sfc; c++) begin
        if (c != 0 || b != 0) @(negedge clk);
        obs = {obs[62:0], o_tx};
      end
      obs_sym[b] = obs;
      check($sformatf("%s sym%0d", tag, b), obs, expv);
    end
  endtask

  initial begin
    // Hand-derived symbols for seed 01, POLY B8, SF 4, msg 1000 (first chip in MSB)
    dir_tbl[0] = 8'b1000_1000;
    dir_tbl[1] = 8'b1110_0001;
    dir_tbl[2] = 8'b0010_1101;
    dir_tbl[3] = 8'b0101_1010;

    rst_n = 1'b0; i_msg = '0; i_send = 1'b0; i_sf = '0; i_seed = '0; i_load_seed = 1'b0;
    mstate = 8'h01;
    repeat (2) @(negedge clk);
    check("rst_tx",    64'(o_tx),    64'd0);
    check("rst_busy",  64'(o_busy),  64'd0);
    check("rst_done",  64'(o_done),  64'd0);
    check("rst_ready", 64'(o_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame, directed chip pattern
    start(4'b1000, 2'd0, 1'b0, 8'h00);
    check("t1_busy", 64'(o_busy), 64'd1);
    collect(4'b1000, 2'd0, "t1");
    for (int i = 0; i < 4; i++) check($sformatf("t1_dir%0d", i), obs_sym[i], 64'(dir_tbl[i]));
    @(negedge clk);
    check("t1_done", 64'(o_done), 64'd1);
    check("t1_busy_end", 64'(o_busy), 64'd0);
    check("t1_tx_idle", 64'(o_tx), 64'd0);

    // SF 32, all-ones message; mid-frame sf change and seed load must be ignored
    start(4'hF, 2'd3, 1'b0, 8'h00);
    i_sf = 2'd0; i_load_seed = 1'b1; i_seed = 8'h55;
    collect(4'hF, 2'd3, "t2");
    i_load_seed = 1'b0;
    for (int i = 0; i < NB; i++) check($sformatf("t2_halves%0d", i), 64'(obs_sym[i][63:32]), 64'(obs_sym[i][31:0]));
    @(negedge clk);
    check("t2_done", 64'(o_done), 64'd1);

    // Seed load alone in IDLE, then a frame
    i_load_seed = 1'b1; i_seed = 8'h3C;
    @(negedge clk);
    i_load_seed = 1'b0;
    mstate = 8'h3C;
    start(4'b0110, 2'd1, 1'b0, 8'h00);
    collect(4'b0110, 2'd1, "t3a");
    @(negedge clk);
    check("t3a_done", 64'(o_done), 64'd1);

    // Zero seed loaded together with the send: frame starts from state 1
    mstate = 8'h01;
    start(4'b1000, 2'd0, 1'b1, 8'h00);
    collect(4'b1000, 2'd0, "t3b");
    for (int i = 0; i < 4; i++) check($sformatf("t3b_dir%0d", i), obs_sym[i], 64'(dir_tbl[i]));
    @(negedge clk);

    // Back-to-back frames through the pending slot
    start(4'b0101, 2'd0, 1'b0, 8'h00);
    fork
      collect(4'b0101, 2'd0, "t4a");
      begin
        repeat (3) @(negedge clk);
        i_msg = 4'b1100; i_sf = 2'd1; i_send = 1'b1;
        @(negedge clk);
        i_send = 1'b0; i_sf = 2'd0;
        check("t4_ready_low", 64'(o_ready), 64'd0);
      end
    join
    check("t4_ready_last", 64'(o_ready), 64'd0);
    @(negedge clk);
    check("t4_done", 64'(o_done), 64'd1);
    check("t4_busy", 64'(o_busy), 64'd1);
    check("t4_ready_back", 64'(o_ready), 64'd1);
    collect(4'b1100, 2'd1, "t4b");
    @(negedge clk);
    check("t4b_done", 64'(o_done), 64'd1);
    check("t4b_busy", 64'(o_busy), 64'd0);

    // Async reset in the middle of a data half, with a frame pending
    start(4'b1111, 2'd0, 1'b0, 8'h00);
    i_msg = 4'b0011; i_send = 1'b1;
    @(negedge clk);
    i_send = 1'b0;
    check("t5_pend", 64'(o_ready), 64'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_tx",    64'(o_tx),    64'd0);
    check("t5_busy",  64'(o_busy),  64'd0);
    check("t5_ready", 64'(o_ready), 64'd1);
    check("t5_done",  64'(o_done),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mstate = 8'h01;
    start(4'b1000, 2'd0, 1'b0, 8'h00);
    collect(4'b1000, 2'd0, "t5r");
    for (int i = 0; i < 4; i++) check($sformatf("t5r_dir%0d", i), obs_sym[i], 64'(dir_tbl[i]));
    @(negedge clk);
    check("t5r_done", 64'(o_done), 64'd1);
    @(negedge clk);
    check("t5r_idle", 64'(o_busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
